// File: rtl/regfl_rdseq.sv
// ============================================================================
// regfl_rdseq : streams a run of consecutive register-file words over valid/ready
// Optional: REGFL_RDSEQ_PARITY_EN adds registered even-parity output rd_par
// Revision: 1.0
// ============================================================================
`default_nettype none

module regfl_rdseq #(
  parameter int NREG  = 8,
  parameter int WIDTH = 64,
  parameter int IW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  start,
  input  logic [IW-1:0]         base,
  input  logic [IW:0]           cnt,
  input  logic [NREG*WIDTH-1:0] q_in,
  output logic [WIDTH-1:0]      rd_data,
  output logic [IW-1:0]         rd_idx,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done
`ifdef REGFL_RDSEQ_PARITY_EN
  ,
  output logic                  rd_par
`endif
);

  localparam logic [IW:0] c_nreg = (IW+1)'(NREG);
  localparam logic [IW:0] c_one  = (IW+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW:0]      r_rem;
  logic [IW:0]      w_rem_nxt;
  logic [IW-1:0]    w_idx_nxt;
  logic             w_valid_nxt;
  logic             w_load;
  logic             w_xfer;
  logic [WIDTH-1:0] w_regs [NREG];

  // Register 0 sits in the most significant slice of the flattened bus.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_unpack
      assign w_regs[gi] = q_in[NREG*WIDTH-1-gi*WIDTH -: WIDTH];
    end
  endgenerate

  assign w_xfer = rd_valid & rd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_idx_nxt   = rd_idx;
    w_valid_nxt = rd_valid;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
          w_idx_nxt   = base;
          w_rem_nxt   = (cnt == '0) ? c_nreg : cnt;
          w_valid_nxt = 1'b1;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (r_rem > c_one) begin
            w_load    = 1'b1;
            w_idx_nxt = rd_idx + 1'b1;
            w_rem_nxt = r_rem - c_one;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = FIN;
          end
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rem    <= w_rem_nxt;
      rd_idx   <= w_idx_nxt;
      rd_valid <= w_valid_nxt;
    end
  end

  // Words are picked from q_in only at the edge they are loaded; no run snapshot.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_data <= '0;
    end else if (w_load) begin
      rd_data <= w_regs[w_idx_nxt];
    end
  end

`ifdef REGFL_RDSEQ_PARITY_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      rd_par <= 1'b0;
    end else if (w_load) begin
      rd_par <= ^w_regs[w_idx_nxt];
    end
  end
`endif

  assign busy = (r_state != IDLE);
  assign done = (r_state == FIN);

endmodule

`default_nettype wire

// File: tb/tb_regfl_rdseq.sv
// ============================================================================
// tb_regfl_rdseq : randomized self-checking bench against a queue-based model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_regfl_rdseq;

  logic         clk;
  logic         rst_b;
  logic         start;
  logic [2:0]   base;
  logic [3:0]   cnt;
  logic [511:0] q_in;
  logic [63:0]  rd_data;
  logic [2:0]   rd_idx;
  logic         rd_valid;
  logic         rd_ready;
  logic         busy;
  logic         done;
`ifdef REGFL_RDSEQ_PARITY_EN
  logic         rd_par;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer   = 0;
  int n_done   = 0;

  // Model: queue of indices still to be offered, the word currently offered, FIN flag.
  int          m_q[$];
  logic [63:0] m_data;
  bit          m_fin;

  regfl_rdseq dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .base     (base),
    .cnt      (cnt),
    .q_in     (q_in),
    .rd_data  (rd_data),
    .rd_idx   (rd_idx),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .busy     (busy),
    .done     (done)
`ifdef REGFL_RDSEQ_PARITY_EN
    ,
    .rd_par   (rd_par)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] word(input logic [511:0] q, input int i);
    return q[511 - i*64 -: 64];
  endfunction

  function automatic logic [511:0] preload();
    logic [511:0] q;
    for (int i = 0; i < 8; i++) q[511 - i*64 -: 64] = 64'(i + 1);
    return q;
  endfunction

  // Check the outputs left by the previous edge, then drive the next inputs and
  // advance the model by the edge those inputs will see.
  task automatic step(input logic s, input logic [2:0] b, input logic [3:0] c,
                      input logic r, input bit rq);
    int n;
    @(negedge clk);
    chk("valid", 64'(rd_valid), 64'(m_q.size() != 0));
    chk("busy",  64'(busy),     64'(m_q.size() != 0 || m_fin));
    chk("done",  64'(done),     64'(m_fin));
    if (m_q.size() != 0) begin
      chk("idx",  64'(rd_idx), 64'(m_q[0]));
      chk("data", rd_data,     m_data);
`ifdef REGFL_RDSEQ_PARITY_EN
      chk("par",  64'(rd_par), 64'(^m_data));
`endif
    end
    if (rd_valid && r) n_xfer++;
    if (done) n_done++;

    start    = s;
    base     = b;
    cnt      = c;
    rd_ready = r;
    if (rq) for (int i = 0; i < 16; i++) q_in[i*32 +: 32] = $urandom;

    if (m_fin) begin
      m_fin = 0;
    end else if (m_q.size() == 0) begin
      if (s) begin
        n = (c == 0) ? 8 : int'(c);
        for (int k = 0; k < n; k++) m_q.push_back((int'(b) + k) % 8);
        m_data = word(q_in, int'(b));
      end
    end else if (r) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_fin = 1;
      else m_data = word(q_in, m_q[0]);
    end
  endtask

  task automatic reset_mid_run();
    @(negedge clk);
    start = 1'b0;
    #1 rst_b = 1'b0;
    #1;
    chk("rst_valid", 64'(rd_valid), 64'd0);
    chk("rst_busy",  64'(busy),     64'd0);
    chk("rst_done",  64'(done),     64'd0);
    chk("rst_data",  rd_data,       64'd0);
    chk("rst_idx",   64'(rd_idx),   64'd0);
    m_q.delete();
    m_fin = 0;
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  initial begin
    rst_b    = 1'b0;
    start    = 1'b0;
    base     = '0;
    cnt      = '0;
    rd_ready = 1'b0;
    q_in     = preload();
    m_data   = '0;
    m_fin    = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_valid", 64'(rd_valid), 64'd0);
    chk("init_busy",  64'(busy),     64'd0);
    chk("init_data",  rd_data,       64'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // Run of 3 from reg 2 at full rate.
    step(1'b1, 3'd2, 4'd3, 1'b1, 0);
    repeat (6) step(1'b0, 3'd0, 4'd0, 1'b1, 0);

    // Wrapping run 6,7,0,1.
    step(1'b1, 3'd6, 4'd4, 1'b1, 0);
    repeat (7) step(1'b0, 3'd0, 4'd0, 1'b1, 0);

    // Full-file run with ready toggling; count transfers and done pulses.
    n_xfer = 0;
    n_done = 0;
    step(1'b1, 3'd0, 4'd0, 1'b0, 0);
    for (int i = 0; i < 20; i++) step(1'b0, 3'd0, 4'd0, (i % 2) == 0, 0);
    chk("xfers", 64'(n_xfer), 64'd8);
    chk("dones", 64'(n_done), 64'd1);

    // start pulsed during SEND and FIN must not restart or extend the run.
    n_xfer = 0;
    n_done = 0;
    step(1'b1, 3'd1, 4'd2, 1'b1, 0);
    step(1'b1, 3'd5, 4'd7, 1'b1, 0);
    step(1'b1, 3'd5, 4'd7, 1'b1, 0);
    step(1'b1, 3'd5, 4'd7, 1'b1, 0);
    repeat (4) step(1'b0, 3'd0, 4'd0, 1'b1, 0);
    chk("ign_xfers", 64'(n_xfer), 64'd2);
    chk("ign_dones", 64'(n_done), 64'd1);

    // Reset while a word is held in SEND.
    step(1'b1, 3'd4, 4'd5, 1'b0, 0);
    step(1'b0, 3'd0, 4'd0, 1'b0, 0);
    reset_mid_run();
    repeat (3) step(1'b0, 3'd0, 4'd0, 1'b1, 0);

`ifdef REGFL_RDSEQ_PARITY_EN
    q_in = preload();
    q_in[511 - 3*64 -: 64] = 64'h7;
    q_in[511 -: 64]        = 64'h3;
    step(1'b1, 3'd3, 4'd1, 1'b0, 0);
    step(1'b0, 3'd0, 4'd0, 1'b1, 0);
    chk("par_reg3", 64'(rd_par), 64'd1);
    repeat (3) step(1'b0, 3'd0, 4'd0, 1'b1, 0);
    step(1'b1, 3'd0, 4'd1, 1'b0, 0);
    step(1'b0, 3'd0, 4'd0, 1'b1, 0);
    chk("par_reg0", 64'(rd_par), 64'd0);
    repeat (3) step(1'b0, 3'd0, 4'd0, 1'b1, 0);
`endif

    // Random traffic with q_in changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
           4'($urandom_range(0, 8)), $urandom_range(0, 9) < 7, 1);
      if (i == 1500) reset_mid_run();
    end
    repeat (12) step(1'b0, 3'd0, 4'd0, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
